// File: rtl/maze_pkg.sv
// Shared maze types: map geometry, bank encodings, arbiter FSM states and
// the owner tags carried down the map ROM read pipeline.
package maze_pkg;

    localparam int MAP_WIDTH = 30;
    localparam int MAP_DEPTH = 21;
    localparam int MAP_ADDRW = 5;
    localparam int MAP_BANKW = 2;

    typedef enum logic [1:0] {
        BANK_EASY   = 2'd0,
        BANK_MEDIUM = 2'd1,
        BANK_HARD   = 2'd2
    } bank_t;

    typedef enum logic [1:0] {
        ARB_RUN    = 2'd0,
        ARB_DRAIN  = 2'd1,
        ARB_SWITCH = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_GAME = 2'd2
    } owner_t;

    // One pipeline slot: who owns the read, the captured column and whether
    // the ROM word must be overridden because the access is out of bounds.
    typedef struct packed {
        owner_t     own;
        logic [7:0] col;
        logic       oob;
    } pipe_tag_t;

endpackage

// File: rtl/map_rd_pipe.sv
// Two-stage read pipeline behind the map ROM: carries owner tag, column and
// out-of-bounds flag through S1/S2 and registers the per-requester results.
module map_rd_pipe
    import maze_pkg::*;
#(
    parameter int WIDTH = MAP_WIDTH
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             grant_i,
    input  logic [1:0]       grant_own_i,
    input  logic [7:0]       grant_col_i,
    input  logic             grant_oob_i,
    input  logic [WIDTH-1:0] rom_data_i,
    output logic [1:0]       s1_own_o,
    output logic [1:0]       s2_own_o,
    output logic             vga_valid_o,
    output logic [WIDTH-1:0] vga_data_o,
    output logic             game_valid_o,
    output logic             game_hit_o
);

    pipe_tag_t        s1_d, s1_q, s2_q;
    logic             vga_valid_q, game_valid_q, game_hit_q;
    logic [WIDTH-1:0] vga_data_q;
    logic [WIDTH-1:0] col_shift;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        s1_d = '0;
        if (grant_i) begin
            s1_d.own = owner_t'(grant_own_i);
            s1_d.col = grant_col_i;
            s1_d.oob = grant_oob_i;
        end
    end

    // A column past the row width shifts to zero; the oob flag covers that case.
    assign col_shift = rom_data_i >> s2_q.col;

    // NOTE: sequential state uses non-blocking assignments so all stages advance together.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            s1_q         <= '0;
            s2_q         <= '0;
            vga_valid_q  <= 1'b0;
            vga_data_q   <= '0;
            game_valid_q <= 1'b0;
            game_hit_q   <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s1_q;
            vga_valid_q  <= (s2_q.own == OWN_VGA);
            game_valid_q <= (s2_q.own == OWN_GAME);
            if (s2_q.own == OWN_VGA) begin
                vga_data_q <= s2_q.oob ? '1 : rom_data_i;
            end
            if (s2_q.own == OWN_GAME) begin
                game_hit_q <= s2_q.oob | col_shift[0];
            end
        end
    end

    assign s1_own_o     = s1_q.own;
    assign s2_own_o     = s2_q.own;
    assign vga_valid_o  = vga_valid_q;
    assign vga_data_o   = vga_data_q;
    assign game_valid_o = game_valid_q;
    assign game_hit_o   = game_hit_q;

endmodule

// File: rtl/map_rom_arbiter.sv
// Shares the synchronous map ROM between the VGA row fetch and the game
// collision lookup, and drains in-flight reads before swapping map banks.
module map_rom_arbiter
    import maze_pkg::*;
#(
    parameter int WIDTH = MAP_WIDTH,
    parameter int DEPTH = MAP_DEPTH,
    parameter int ADDRW = MAP_ADDRW,
    parameter int BANKW = MAP_BANKW
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic                   vga_req,
    input  logic [ADDRW-1:0]       vga_row,
    output logic                   vga_valid,
    output logic [WIDTH-1:0]       vga_data,
    input  logic                   game_req,
    input  logic [ADDRW-1:0]       game_row,
    input  logic [7:0]             game_col,
    output logic                   game_valid,
    output logic                   game_hit,
    input  logic [BANKW-1:0]       bank_sel,
    output logic [BANKW-1:0]       bank_cur,
    output logic                   bank_busy,
    output logic [BANKW+ADDRW-1:0] rom_addr,
    input  logic [WIDTH-1:0]       rom_data
);

    localparam logic [ADDRW:0] DEPTH_C = (ADDRW + 1)'(DEPTH);
    localparam logic [8:0]     WIDTH_C = 9'(WIDTH);

    arb_state_t             state_d, state_q;
    logic [BANKW-1:0]       bank_cur_q;
    logic                   bank_busy_q;
    logic [BANKW+ADDRW-1:0] rom_addr_q;

    logic                   grant;
    owner_t                 grant_own;
    logic [ADDRW-1:0]       grant_row;
    logic [7:0]             grant_col;
    logic                   grant_oob;
    logic [1:0]             s1_own_raw, s2_own_raw;
    owner_t                 s1_own, s2_own;
    logic                   vga_busy, game_busy;

    assign s1_own = owner_t'(s1_own_raw);
    assign s2_own = owner_t'(s2_own_raw);

    // A requester is busy exactly while its read occupies S1 or S2.
    assign vga_busy  = (s1_own == OWN_VGA)  || (s2_own == OWN_VGA);
    assign game_busy = (s1_own == OWN_GAME) || (s2_own == OWN_GAME);

    always_comb begin
        state_d   = state_q;
        grant     = 1'b0;
        grant_own = OWN_NONE;
        grant_row = '0;
        grant_col = '0;
        unique case (state_q)
            ARB_RUN: begin
                if (vga_req && !vga_busy) begin
                    grant     = 1'b1;
                    grant_own = OWN_VGA;
                    grant_row = vga_row;
                end else if (game_req && !game_busy) begin
                    grant     = 1'b1;
                    grant_own = OWN_GAME;
                    grant_row = game_row;
                    grant_col = game_col;
                end
                if (bank_sel != bank_cur_q) begin
                    state_d = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                if (s1_own == OWN_NONE && s2_own == OWN_NONE) begin
                    state_d = ARB_SWITCH;
                end
            end
            ARB_SWITCH: state_d = ARB_RUN;
            default:    state_d = ARB_RUN;
        endcase
    end

    // Row bound applies to both requesters; column bound only to collision lookups.
    assign grant_oob = ({1'b0, grant_row} >= DEPTH_C) ||
                       ((grant_own == OWN_GAME) && ({1'b0, grant_col} >= WIDTH_C));

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ARB_RUN;
            bank_cur_q  <= BANKW'(BANK_EASY);
            bank_busy_q <= 1'b0;
            rom_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            bank_busy_q <= (state_d != ARB_RUN);
            if (state_q == ARB_SWITCH) begin
                bank_cur_q <= bank_sel;
            end
            if (grant) begin
                rom_addr_q <= {bank_cur_q, grant_row};
            end
        end
    end

    map_rd_pipe #(
        .WIDTH (WIDTH)
    ) u_pipe (
        .clk          (clk),
        .Reset        (Reset),
        .grant_i      (grant),
        .grant_own_i  (grant_own),
        .grant_col_i  (grant_col),
        .grant_oob_i  (grant_oob),
        .rom_data_i   (rom_data),
        .s1_own_o     (s1_own_raw),
        .s2_own_o     (s2_own_raw),
        .vga_valid_o  (vga_valid),
        .vga_data_o   (vga_data),
        .game_valid_o (game_valid),
        .game_hit_o   (game_hit)
    );

    assign bank_cur  = bank_cur_q;
    assign bank_busy = bank_busy_q;
    assign rom_addr  = rom_addr_q;

endmodule

// File: tb/tb_map_rom_arbiter.sv
// Directed bench for map_rom_arbiter with a behavioural synchronous-read ROM.
module tb_map_rom_arbiter;

    localparam int WIDTH = 30;
    localparam int ADDRW = 5;
    localparam int BANKW = 2;

    logic                   clk;
    logic                   Reset;
    logic                   vga_req;
    logic [ADDRW-1:0]       vga_row;
    logic                   vga_valid;
    logic [WIDTH-1:0]       vga_data;
    logic                   game_req;
    logic [ADDRW-1:0]       game_row;
    logic [7:0]             game_col;
    logic                   game_valid;
    logic                   game_hit;
    logic [BANKW-1:0]       bank_sel;
    logic [BANKW-1:0]       bank_cur;
    logic                   bank_busy;
    logic [BANKW+ADDRW-1:0] rom_addr;
    logic [WIDTH-1:0]       rom_data;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    map_rom_arbiter dut (
        .clk        (clk),
        .Reset      (Reset),
        .vga_req    (vga_req),
        .vga_row    (vga_row),
        .vga_valid  (vga_valid),
        .vga_data   (vga_data),
        .game_req   (game_req),
        .game_row   (game_row),
        .game_col   (game_col),
        .game_valid (game_valid),
        .game_hit   (game_hit),
        .bank_sel   (bank_sel),
        .bank_cur   (bank_cur),
        .bank_busy  (bank_busy),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Map contents: bank 0 row 3 is a fixed pattern, every other word repeats its address.
    function automatic logic [WIDTH-1:0] rom_fn(input logic [6:0] a);
        if (a == 7'd3) return 30'h0000_0F0F;
        return {a, a, a, a, 2'b01};
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    function automatic logic exp_hit(input logic [1:0] bank, input logic [4:0] row,
                                     input logic [7:0] col);
        logic [WIDTH-1:0] w;
        if (row >= 5'd21 || col >= 8'd30) return 1'b1;
        w = rom_fn({bank, row});
        return w[col[4:0]];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vga_txn(input logic [4:0] row, input logic [WIDTH-1:0] exp, input string tag);
        vga_row = row;
        vga_req = 1'b1;
        tick();
        check({tag, "_v0"}, 32'(vga_valid), 32'd0);
        tick();
        check({tag, "_v1"}, 32'(vga_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(vga_valid), 32'd1);
        check({tag, "_data"}, 32'(vga_data), 32'(exp));
        vga_req = 1'b0;
        tick();
        check({tag, "_pulse"}, 32'(vga_valid), 32'd0);
    endtask

    task automatic game_txn(input logic [4:0] row, input logic [7:0] col, input logic exp,
                            input string tag);
        game_row = row;
        game_col = col;
        game_req = 1'b1;
        tick();
        check({tag, "_v0"}, 32'(game_valid), 32'd0);
        tick();
        check({tag, "_v1"}, 32'(game_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(game_valid), 32'd1);
        check({tag, "_hit"}, 32'(game_hit), 32'(exp));
        game_req = 1'b0;
        tick();
        check({tag, "_pulse"}, 32'(game_valid), 32'd0);
    endtask

    initial begin
        Reset    = 1'b1;
        vga_req  = 1'b0;
        vga_row  = '0;
        game_req = 1'b0;
        game_row = '0;
        game_col = '0;
        bank_sel = '0;

        // Reset state
        tick();
        tick();
        check("rst_vga_valid", 32'(vga_valid), 32'd0);
        check("rst_vga_data", 32'(vga_data), 32'd0);
        check("rst_game_valid", 32'(game_valid), 32'd0);
        check("rst_game_hit", 32'(game_hit), 32'd0);
        check("rst_bank_cur", 32'(bank_cur), 32'd0);
        check("rst_bank_busy", 32'(bank_busy), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        Reset = 1'b0;
        tick();

        // VGA only: row 3, rom_addr captured at grant, single pulse, no regrant
        vga_row = 5'd3;
        vga_req = 1'b1;
        tick();
        check("vga1_addr", 32'(rom_addr), 32'h03);
        check("vga1_v0", 32'(vga_valid), 32'd0);
        tick();
        check("vga1_v1", 32'(vga_valid), 32'd0);
        tick();
        check("vga1_valid", 32'(vga_valid), 32'd1);
        check("vga1_data", 32'(vga_data), 32'h0000_0F0F);
        vga_req = 1'b0;
        tick();
        check("vga1_after1", 32'(vga_valid), 32'd0);
        tick();
        check("vga1_after2", 32'(vga_valid), 32'd0);

        // Simultaneous requests: VGA at k, game at k+1
        vga_row  = 5'd3;
        game_row = 5'd3;
        game_col = 8'd4;
        vga_req  = 1'b1;
        game_req = 1'b1;
        tick();
        check("sim_k_vv", 32'(vga_valid), 32'd0);
        check("sim_k_gv", 32'(game_valid), 32'd0);
        tick();
        check("sim_k1_vv", 32'(vga_valid), 32'd0);
        check("sim_k1_gv", 32'(game_valid), 32'd0);
        tick();
        check("sim_k2_vv", 32'(vga_valid), 32'd1);
        check("sim_k2_vdata", 32'(vga_data), 32'h0000_0F0F);
        check("sim_k2_gv", 32'(game_valid), 32'd0);
        vga_req = 1'b0;
        tick();
        check("sim_k3_vv", 32'(vga_valid), 32'd0);
        check("sim_k3_gv", 32'(game_valid), 32'd1);
        check("sim_k3_hit", 32'(game_hit), 32'd0);
        game_req = 1'b0;
        tick();
        check("sim_k4_gv", 32'(game_valid), 32'd0);

        // Bounds and ordinary hits
        game_txn(5'd21, 8'd1, 1'b1, "oob_row");
        game_txn(5'd3, 8'd30, 1'b1, "oob_col");
        game_txn(5'd3, 8'd0, 1'b1, "hit_r3c0");
        game_txn(5'd3, 8'd8, 1'b1, "hit_r3c8");
        game_txn(5'd5, 8'd29, exp_hit(2'd0, 5'd5, 8'd29), "hit_r5c29");
        game_txn(5'd5, 8'd2, exp_hit(2'd0, 5'd5, 8'd2), "hit_r5c2");
        vga_txn(5'd25, 30'h3FFF_FFFF, "vga_oob");
        vga_txn(5'd20, rom_fn(7'd20), "vga_r20");

        // Bank switch with a game read in flight
        check("bs_busy_pre", 32'(bank_busy), 32'd0);
        game_row = 5'd5;
        game_col = 8'd8;
        game_req = 1'b1;
        tick();
        check("bs_addr_k", 32'(rom_addr), 32'h05);
        bank_sel = 2'd2;
        tick();
        check("bs_busy_k1", 32'(bank_busy), 32'd1);
        check("bs_cur_k1", 32'(bank_cur), 32'd0);
        vga_row = 5'd4;
        vga_req = 1'b1;
        tick();
        check("bs_gv_k2", 32'(game_valid), 32'd1);
        check("bs_hit_k2", 32'(game_hit), 32'(exp_hit(2'd0, 5'd5, 8'd8)));
        check("bs_addr_k2", 32'(rom_addr), 32'h05);
        check("bs_busy_k2", 32'(bank_busy), 32'd1);
        game_req = 1'b0;
        tick();
        check("bs_busy_k3", 32'(bank_busy), 32'd1);
        check("bs_cur_k3", 32'(bank_cur), 32'd0);
        check("bs_addr_k3", 32'(rom_addr), 32'h05);
        tick();
        check("bs_busy_k4", 32'(bank_busy), 32'd0);
        check("bs_cur_k4", 32'(bank_cur), 32'd2);
        check("bs_addr_k4", 32'(rom_addr), 32'h05);
        tick();
        check("bs_addr_k5", 32'(rom_addr), 32'h44);
        tick();
        check("bs_vv_k6", 32'(vga_valid), 32'd0);
        tick();
        check("bs_vv_k7", 32'(vga_valid), 32'd1);
        check("bs_vdata_k7", 32'(vga_data), 32'(rom_fn(7'h44)));
        vga_req = 1'b0;
        tick();
        check("bs_vv_k8", 32'(vga_valid), 32'd0);

        // Reset with both requesters in flight
        vga_row  = 5'd3;
        game_row = 5'd3;
        game_col = 8'd0;
        vga_req  = 1'b1;
        game_req = 1'b1;
        tick();
        tick();
        Reset = 1'b1;
        #1;
        vga_req  = 1'b0;
        game_req = 1'b0;
        check("mr_vv", 32'(vga_valid), 32'd0);
        check("mr_gv", 32'(game_valid), 32'd0);
        check("mr_vdata", 32'(vga_data), 32'd0);
        check("mr_hit", 32'(game_hit), 32'd0);
        check("mr_cur", 32'(bank_cur), 32'd0);
        check("mr_busy", 32'(bank_busy), 32'd0);
        check("mr_addr", 32'(rom_addr), 32'd0);
        tick();
        check("mr_vv1", 32'(vga_valid), 32'd0);
        check("mr_gv1", 32'(game_valid), 32'd0);
        bank_sel = 2'd0;
        Reset    = 1'b0;
        tick();
        check("mr_vv2", 32'(vga_valid), 32'd0);
        check("mr_gv2", 32'(game_valid), 32'd0);
        tick();
        check("mr_gv3", 32'(game_valid), 32'd0);
        vga_txn(5'd3, 30'h0000_0F0F, "mr_after");

        // Back-to-back streaming: grants alternate, one valid per requester every 3 cycles
        vga_row  = 5'd3;
        game_row = 5'd3;
        game_col = 8'd0;
        vga_req  = 1'b1;
        game_req = 1'b1;
        for (int n = 0; n < 16; n++) begin
            logic ev, eg;
            tick();
            ev = (n == 2) || (n == 5) || (n == 8) || (n == 11);
            eg = (n == 3) || (n == 6) || (n == 9) || (n == 12);
            check($sformatf("str_vv_%0d", n), 32'(vga_valid), 32'(ev));
            check($sformatf("str_gv_%0d", n), 32'(game_valid), 32'(eg));
            if (ev) check($sformatf("str_vdata_%0d", n), 32'(vga_data), 32'h0000_0F0F);
            if (eg) check($sformatf("str_hit_%0d", n), 32'(game_hit), 32'd1);
            if (n == 11) begin
                vga_req  = 1'b0;
                game_req = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
